// File: rtl/sabr_mul_pkg.sv
// Shared definitions for the SABR shared-multiplier arbiter: default widths,
// the tag that travels alongside each multiplier slot, and a small
// round-robin helper.
package sabr_mul_pkg;

  localparam int SABR_N_REQ   = 4;
  localparam int SABR_A_W     = 92;
  localparam int SABR_B_W     = 6;
  localparam int SABR_P_W     = 97;
  localparam int SABR_MUL_LAT = 4;

  // Tag ID is sized for the largest supported requester count (8), so one
  // tag type serves every legal N_REQ. The top uses only the low ID_W bits.
  localparam int SABR_ID_W_MAX = 3;

  typedef struct packed {
    logic                     vld;
    logic [SABR_ID_W_MAX-1:0] id;
  } mul_tag_t;

  // Next round-robin position after index idx, wrapping N-1 -> 0 with no gap.
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sabr_mul_pipe.sv
// Clock-enable gated unsigned multiplier: one operand register stage followed
// by MUL_LAT-1 product stages (MUL_LAT >= 2). The whole pipe holds when ce=0.
module sabr_mul_pipe
  import sabr_mul_pkg::*;
#(
  parameter int A_W     = SABR_A_W,
  parameter int B_W     = SABR_B_W,
  parameter int P_W     = SABR_P_W,
  parameter int MUL_LAT = SABR_MUL_LAT
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           ce,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] p
);

  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic [P_W-1:0] p_q [MUL_LAT-1];

  // Operand capture, multiply, then shift the product down the delay stages.
  // NOTE: the data stages are reset as well so the product output reads zero
  // straight out of reset instead of leftover operands from before it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
      for (int i = 0; i < MUL_LAT - 1; i++) p_q[i] <= '0;
    end else if (ce) begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, giving a true shift register independent of order.
      a_q    <= a;
      b_q    <= b;
      p_q[0] <= P_W'(a_q) * P_W'(b_q);
      for (int i = 1; i < MUL_LAT - 1; i++) p_q[i] <= p_q[i-1];
    end
  end

  assign p = p_q[MUL_LAT-2];

endmodule

// File: rtl/sabr_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between N_REQ SABR
// path requesters. A tag (valid + requester ID) rides alongside every
// multiplier slot; the single response port stalls the whole pipe when the
// downstream is not ready.
// Optional build macro: SABR_MUL_ARB_STATS_EN adds saturating per-requester
// grant counters and a stall-cycle counter.
module sabr_mul_arbiter
  import sabr_mul_pkg::*;
#(
  parameter  int N_REQ   = SABR_N_REQ,
  parameter  int A_W     = SABR_A_W,
  parameter  int B_W     = SABR_B_W,
  parameter  int P_W     = SABR_P_W,
  parameter  int MUL_LAT = SABR_MUL_LAT,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [ID_W-1:0]    resp_id,
  output logic [P_W-1:0]     resp_data,
`ifdef SABR_MUL_ARB_STATS_EN
  output logic [N_REQ*32-1:0] stat_grants,
  output logic [31:0]        stat_stalls,
`endif
  output logic               busy
);

  logic            ce;
  logic            grant_any;
  logic [ID_W-1:0] grant_idx;
  logic            xfer;
  logic [ID_W-1:0] rr_ptr;
  int              cand;
  logic [A_W-1:0]  sel_a;
  logic [B_W-1:0]  sel_b;
  mul_tag_t        tag_q [MUL_LAT];

  // Only a valid product the downstream refuses can stall; bubbles never do.
  assign ce = !(resp_valid && !resp_ready);

  // Round-robin search starting at the pointer, wrapping modulo N_REQ.
  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(cand);
      end
    end
  end

  // One-hot accept for the winner; nothing is accepted while stalled or in reset.
  always_comb begin
    req_ready = '0;
    if (reset_n && ce && grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign xfer  = reset_n && ce && grant_any;
  assign sel_a = req_a[grant_idx*A_W +: A_W];
  assign sel_b = req_b[grant_idx*B_W +: B_W];

  // Pointer moves past the winner on a transfer; the tag pipe tracks the
  // multiplier stage for stage, inserting a bubble when nothing was granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
    end else begin
      if (xfer) rr_ptr <= ID_W'(rr_wrap_inc(32'(grant_idx), N_REQ));
      if (ce) begin
        tag_q[0].vld <= xfer;
        tag_q[0].id  <= SABR_ID_W_MAX'(grant_idx);
        for (int i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
    end
  end

  sabr_mul_pipe #(
    .A_W     (A_W),
    .B_W     (B_W),
    .P_W     (P_W),
    .MUL_LAT (MUL_LAT)
  ) u_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .a       (sel_a),
    .b       (sel_b),
    .p       (resp_data)
  );

  assign resp_valid = tag_q[MUL_LAT-1].vld;
  assign resp_id    = tag_q[MUL_LAT-1].id[ID_W-1:0];

  // Busy whenever any slot of the pipe carries a real product.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) busy = busy | tag_q[i].vld;
  end

`ifdef SABR_MUL_ARB_STATS_EN
  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (xfer && (int'(grant_idx) == i) && (stat_grants[i*32 +: 32] != 32'hFFFF_FFFF))
          stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
      end
      if (!ce && (stat_stalls != 32'hFFFF_FFFF)) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sabr_mul_arbiter.sv
// Self-checking bench for sabr_mul_arbiter: a table of grant vectors plus
// hand-written latency, backpressure and reset sequences, with a scoreboard
// queue holding the expected {id, product} of every accepted operand pair.
module tb_sabr_mul_arbiter;
  import sabr_mul_pkg::*;

  localparam int N   = 4;
  localparam int AW  = SABR_A_W;
  localparam int BW  = SABR_B_W;
  localparam int PW  = SABR_P_W;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a = '0;
  logic [N*BW-1:0] req_b = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [IDW-1:0]  resp_id;
  logic [PW-1:0]   resp_data;
  logic            busy;
`ifdef SABR_MUL_ARB_STATS_EN
  logic [N*32-1:0] stat_grants;
  logic [31:0]     stat_stalls;
`endif

  always #5 clk = ~clk;

  sabr_mul_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
`ifdef SABR_MUL_ARB_STATS_EN
    .stat_grants(stat_grants),
    .stat_stalls(stat_stalls),
`endif
    .busy       (busy)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [PW-1:0]  data;
  } exp_t;

  typedef struct {
    logic [N-1:0] vld;
    logic [N-1:0] exp_rdy;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   total = 0;
  int   bad = 0;
  int   resp_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The full product needs A_W+B_W bits; the result port keeps the low P_W.
  function automatic logic [PW-1:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic [127:0] f;
    f = 128'(a) * 128'(b);
    return f[PW-1:0];
  endfunction

  // Drive one cycle just after the falling edge, sample 1 ns later, then
  // wait for the next falling edge. Expected grants feed the scoreboard.
  task automatic cycle(input logic [N-1:0] vld, input logic [N-1:0] exp_rdy, input logic rr,
                       input bit fix, input logic [AW-1:0] fa, input logic [BW-1:0] fb);
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    exp_t          e;
    for (int i = 0; i < N; i++) begin
      if (fix) begin
        a = fa;
        b = fb;
      end else begin
        a = AW'({$urandom(), $urandom(), $urandom()});
        b = BW'($urandom());
      end
      req_a[i*AW +: AW] = a;
      req_b[i*BW +: BW] = b;
      if (exp_rdy[i]) sb.push_back('{id: IDW'(i), data: model(a, b)});
    end
    req_valid  = vld;
    resp_ready = rr;
    #1;
    check("req_ready", 128'(req_ready), 128'(exp_rdy));
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got id %0d with nothing outstanding", resp_id);
      end else begin
        e = sb.pop_front();
        check("resp_id", 128'(resp_id), 128'(e.id));
        check("resp_data", 128'(resp_data), 128'(e.data));
        resp_cnt++;
      end
    end else if (resp_valid && sb.size() > 0) begin
      check("hold_id", 128'(resp_id), 128'(sb[0].id));
      check("hold_data", 128'(resp_data), 128'(sb[0].data));
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cycle('0, '0, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((sb.size() > 0 || busy) && n < max_cycles) begin
      idle();
      n++;
    end
    check("drain_left", 128'(sb.size()), 128'(0));
    check("drain_busy", 128'(busy), 128'(0));
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    sb.delete();
    resp_cnt = 0;
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 4'b0001};
    vecs[1]  = '{4'b0001, 4'b0001};
    vecs[2]  = '{4'b1111, 4'b0010};
    vecs[3]  = '{4'b1111, 4'b0100};
    vecs[4]  = '{4'b1111, 4'b1000};
    vecs[5]  = '{4'b1010, 4'b0010};
    vecs[6]  = '{4'b1010, 4'b1000};
    vecs[7]  = '{4'b0000, 4'b0000};
    vecs[8]  = '{4'b0100, 4'b0100};
    vecs[9]  = '{4'b0100, 4'b0100};
    vecs[10] = '{4'b1001, 4'b1000};
    vecs[11] = '{4'b1001, 4'b0001};

    // Reset state, with requests pending to show ready is held off.
    reset_n   = 1'b0;
    req_valid = '1;
    @(negedge clk);
    #1;
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_resp_id", 128'(resp_id), 128'(0));
    check("rst_resp_data", 128'(resp_data), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
`ifdef SABR_MUL_ARB_STATS_EN
    check("rst_stat_grants", 128'(stat_grants), 128'(0));
    check("rst_stat_stalls", 128'(stat_stalls), 128'(0));
`endif
    do_reset();

    // Single request: 3*5 appears exactly MUL_LAT cycles after acceptance.
    cycle(4'b0001, 4'b0001, 1'b1, 1'b1, AW'(3), BW'(5));
    for (int i = 0; i < 3; i++) begin
      check("lat_early", 128'(resp_valid), 128'(0));
      idle();
    end
    check("lat_valid", 128'(resp_valid), 128'(1));
    check("lat_id", 128'(resp_id), 128'(0));
    check("lat_data", 128'(resp_data), 128'(15));
    idle();
    check("lat_busy_after", 128'(busy), 128'(0));
    check("lat_valid_after", 128'(resp_valid), 128'(0));

    // Widest operands from requester 1 (pointer now 1).
    cycle(4'b0010, 4'b0010, 1'b1, 1'b1, '1, BW'(63));
    drain(12);

    // Table of grant patterns from a fresh pointer.
    do_reset();
    for (int v = 0; v < 12; v++) cycle(vecs[v].vld, vecs[v].exp_rdy, 1'b1, 1'b0, '0, '0);
    drain(12);
    check("table_resp_cnt", 128'(resp_cnt), 128'(11));

    // All four requesting continuously: grants 0,1,2,3,0,1,2,3, one result per cycle.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(4'b1111, 4'(1 << (i % 4)), 1'b1, 1'b0, '0, '0);
    check("cont_resp_cnt4", 128'(resp_cnt), 128'(4));
    for (int i = 0; i < 4; i++) idle();
    check("cont_resp_cnt8", 128'(resp_cnt), 128'(8));
`ifdef SABR_MUL_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("stat_grants_cont", 128'(stat_grants[i*32 +: 32]), 128'(2));
`endif
    drain(12);

    // Backpressure with a full pipe: three stalled cycles, then release.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(4'b1111, 4'(1 << i), 1'b1, 1'b0, '0, '0);
    check("bp_full_valid", 128'(resp_valid), 128'(1));
    for (int i = 0; i < 3; i++) cycle(4'b1111, 4'b0000, 1'b0, 1'b0, '0, '0);
    cycle(4'b1111, 4'b0001, 1'b1, 1'b0, '0, '0);
    cycle(4'b1111, 4'b0010, 1'b1, 1'b0, '0, '0);
    drain(20);
    check("bp_resp_cnt", 128'(resp_cnt), 128'(6));
`ifdef SABR_MUL_ARB_STATS_EN
    check("bp_stat_stalls", 128'(stat_stalls), 128'(3));
`endif

    // Reset pulsed with three products in flight discards them all.
    do_reset();
    cycle(4'b1111, 4'b0001, 1'b1, 1'b0, '0, '0);
    cycle(4'b1111, 4'b0010, 1'b1, 1'b0, '0, '0);
    cycle(4'b1111, 4'b0100, 1'b1, 1'b0, '0, '0);
    idle();
    check("inflight_valid", 128'(resp_valid), 128'(1));
    check("inflight_busy", 128'(busy), 128'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(resp_valid), 128'(0));
    check("mid_rst_id", 128'(resp_id), 128'(0));
    check("mid_rst_data", 128'(resp_data), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
`ifdef SABR_MUL_ARB_STATS_EN
    check("mid_rst_stat_grants", 128'(stat_grants), 128'(0));
`endif
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) idle();
    check("post_rst_valid", 128'(resp_valid), 128'(0));
    check("post_rst_busy", 128'(busy), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
